addr_regs: RTL

- Operand/pointer register file and effective-address adder that drives the dirl, dirh, indirl and indirh inputs of the CPU address multiplexer.
- Captures operand and pointer bytes from the internal data bus.
- Applies X/Y indexing with zero-page wrap or a 16-bit carry.
- For 16-bit carries, inserts a one-cycle high-byte fix-up (6502 page-cross penalty) and signals busy to the control sequencer.

---
 rtl/addr_regs.sv | 102 ++++++++++
 1 files changed

// File: rtl/addr_regs.sv
// addr_regs: operand/pointer registers with indexed effective-address adder and a one-cycle high-byte fix-up.
module addr_regs #(
  parameter bit ZP_WRAP = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] op,
  input  logic       force_fix,
  input  logic [7:0] data_in,
  input  logic [7:0] x,
  input  logic [7:0] y,
  output logic [7:0] dirl,
  output logic [7:0] dirh,
  output logic [7:0] indirl,
  output logic [7:0] indirh,
  output logic       busy,
  output logic       page_cross,
  output logic       cmd_dropped
);
  typedef enum logic {IDLE, FIX} state_t;
  state_t state_q, state_d;
  logic [7:0] dirl_q, dirl_d, dirh_q, dirh_d, indirl_q, indirl_d, indirh_q, indirh_d;
  logic inc_q, inc_d, hsel_q, hsel_d, drop_q, drop_d;
  logic [7:0] idx, base;
  logic [8:0] sum;
  logic fix_op, idx_op, wide;
  assign dirl        = dirl_q;
  assign dirh        = dirh_q;
  assign indirl      = indirl_q;
  assign indirh      = indirh_q;
  assign busy        = state_q == FIX;
  assign page_cross  = state_q == FIX && inc_q;
  assign cmd_dropped = drop_q;
  assign idx    = (op == 4'd6 || op == 4'd8) ? y : x;
  assign base   = op == 4'd9 ? indirl_q : dirl_q;
  assign sum    = {1'b0, base} + {1'b0, idx};
  assign fix_op = op == 4'd7 || op == 4'd8;
  assign idx_op = op == 4'd5 || op == 4'd6 || op == 4'd9;
  assign wide   = fix_op || (!ZP_WRAP && idx_op);
  always_comb begin
    state_d  = IDLE;
    dirl_d   = dirl_q;
    dirh_d   = dirh_q;
    indirl_d = indirl_q;
    indirh_d = indirh_q;
    inc_d    = 1'b0;
    hsel_d   = hsel_q;
    drop_d   = 1'b0;
    if (state_q == FIX) begin
      // hsel_q selects which pair's high byte receives the deferred carry
      if (hsel_q) indirh_d = indirh_q + {7'b0, inc_q};
      else        dirh_d   = dirh_q + {7'b0, inc_q};
      drop_d = op >= 4'd1 && op <= 4'd11;
    end else begin
      case (op)
        4'd1: dirl_d = data_in;
        4'd2: dirh_d = data_in;
        4'd3: indirl_d = data_in;
        4'd4: indirh_d = data_in;
        4'd5, 4'd6, 4'd7, 4'd8: dirl_d = sum[7:0];
        4'd9: indirl_d = sum[7:0];
        4'd10: begin
          dirl_d = indirl_q;
          dirh_d = indirh_q;
        end
        4'd11: begin
          dirl_d   = 8'h00;
          dirh_d   = 8'h00;
          indirl_d = 8'h00;
          indirh_d = 8'h00;
        end
        default: ;
      endcase
      if (wide && (sum[8] || (fix_op && force_fix))) begin
        state_d = FIX;
        inc_d   = sum[8];
        hsel_d  = op == 4'd9;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      dirl_q   <= 8'h00;
      dirh_q   <= 8'h00;
      indirl_q <= 8'h00;
      indirh_q <= 8'h00;
      inc_q    <= 1'b0;
      hsel_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dirl_q   <= dirl_d;
      dirh_q   <= dirh_d;
      indirl_q <= indirl_d;
      indirh_q <= indirh_d;
      inc_q    <= inc_d;
      hsel_q   <= hsel_d;
      drop_q   <= drop_d;
    end
  end
endmodule
